prach_hb4_pair: RTL and testbench
=================================

Name: prach_hb4_pair

Overview:
- Polyphase pairing stage directly upstream of the PRACH half-band-by-2 decimator (hb4).
- Takes the channel-interleaved TDM sample stream and buffers the first sample of each per-channel pair.
- On the second sample of the pair, emits both samples together as the two polyphase branches (dp1/dp2) the decimator consumes.
- Output valid rate per channel is half the input rate; channel tag and frame sync travel alongside.

Parameters:
- NUM_CHANNEL, 128, channel slot space; din_chn range; depth of pairing RAM and phase vector.
- NUM_CHANNEL_USED, 48, channels chn < NUM_CHANNEL_USED are processed; others dropped.
- DATA_WIDTH, 16, sample width (signed, passed through unmodified).

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous reset, active-high.
- din_dq  input  DATA_WIDTH  input sample.
- din_dv  input  1  input sample valid.
- din_chn  input  8  channel index of din_dq.
- sync_in  input  1  frame sync pulse; restarts pairing.
- dout_dp1  output  DATA_WIDTH  second (newer) sample of pair; center-tap branch.
- dout_dp2  output  DATA_WIDTH  first (older) sample of pair; symmetric-FIR branch.
- dout_dv  output  1  pair valid.
- dout_chn  output  8  channel index of pair.
- sync_out  output  1  sync_in delayed by LATENCY (2).
- drop_cnt  output  16  saturating count of dropped samples (chn >= NUM_CHANNEL_USED).

Behaviour:
- Reset (rst=1 at clk edge): dout_dp1/dp2=0, dout_dv=0, dout_chn=0, sync_out=0, drop_cnt=0, all phase bits=0, pipeline valids=0. Pairing RAM contents are not cleared (don't-care).
- State per channel: 1 phase bit (0 = awaiting first sample, 1 = first sample held) plus one RAM word (NUM_CHANNEL x DATA_WIDTH, MLAB/distributed).
- Stage 1 (cycle of din_dv=1, chn valid):
  - Read phase[chn].
  - If phase=0: write din_dq to ram[chn], set phase[chn]=1, no output.
  - If phase=1: read ram[chn], set phase[chn]=0, mark pair valid.
- Stage 2: register outputs: dout_dp2=ram[chn], dout_dp1=din_dq, dout_chn=chn, dout_dv=1.
- Latency: dout_dv asserts exactly 2 clk after the din_dv cycle carrying the second sample. dout_dv=0 otherwise.
- Data hold: dout_dp1/dp2/chn hold last value when dout_dv=0.
- din_dv=0: no state change; din_dq/din_chn ignored.
- Dropped samples: chn >= NUM_CHANNEL_USED with din_dv=1 are dropped (no RAM/phase change) and drop_cnt increments, saturating at 0xFFFF.
- sync_in=1:
  - Clears all phase bits in that cycle.
  - If din_dv=1 in the same cycle, that sample is treated as phase 0 (first of a new pair) after the clear. Sync has priority.
  - An in-flight stage-2 pair still emits.
- sync_out: pure 2-cycle delay of sync_in, independent of din_dv; cleared by rst.
- Same-channel back-to-back: consecutive din_dv cycles on the same chn must pair correctly. Phase/RAM updates are visible to the next cycle (write-first or bypass required).
- Reset mid-operation: held half-pairs are discarded (phase cleared); no output for 2 cycles after rst deassert unless new pairs complete.
- No backpressure: downstream always accepts.

Test Plan:
- Reset then chn=0 samples 100,200 (dv on 2 consecutive cycles) -> one output 2 clk after 200: dp2=100, dp1=200, chn=0, dv=1. No output after 100.
- Round-robin chn 0..47, samples v=chn*2 then v=chn*2+1 over two rounds -> 48 outputs in round 2, each dp2=2c, dp1=2c+1, chn=c, in order.
- chn=5 sample 7, then sync_in with dv chn=5 sample 9, then chn=5 sample 11 -> single output dp2=9, dp1=11. Value 7 discarded. sync_out high 2 clk after sync_in.
- din_dv=1 with chn=60, 3 times -> no dout_dv, drop_cnt=3. Phase of chn 60 unaffected. 70000 drops -> drop_cnt=0xFFFF.
- Interleaved chn 3 samples 1,2,3,4 with din_dv=0 gaps of random length -> outputs (dp2,dp1)=(1,2),(3,4).
- Assert rst after chn=9 first sample 50; release; chn=9 sample 60, 61 -> output dp2=60, dp1=61 only.

Source files
------------

// File: rtl/prach_hb4_pair_if.sv
// Sample-in / pair-out bundle between the TDM sample source, the pairing stage and the hb4 decimator.
interface prach_hb4_pair_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CHN_WIDTH  = 8,
  parameter int unsigned DROP_WIDTH = 16
);

  logic [DATA_WIDTH-1:0] din_dq;
  logic                  din_dv;
  logic [CHN_WIDTH-1:0]  din_chn;
  logic                  sync_in;

  logic [DATA_WIDTH-1:0] dout_dp1;
  logic [DATA_WIDTH-1:0] dout_dp2;
  logic                  dout_dv;
  logic [CHN_WIDTH-1:0]  dout_chn;
  logic                  sync_out;
  logic [DROP_WIDTH-1:0] drop_cnt;

  modport master (
    output din_dq, din_dv, din_chn, sync_in,
    input  dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out, drop_cnt
  );

  modport slave (
    input  din_dq, din_dv, din_chn, sync_in,
    output dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out, drop_cnt
  );

endinterface

// File: rtl/prach_hb4_pair.sv
// Polyphase pairing ahead of the PRACH hb4 decimator: holds the first sample of each
// per-channel pair and emits (newer, older) as the dp1/dp2 branches on the second sample.
module prach_hb4_pair #(
  parameter int unsigned NUM_CHANNEL      = 128,
  parameter int unsigned NUM_CHANNEL_USED = 48,
  parameter int unsigned DATA_WIDTH       = 16
) (
  input  logic            clk,
  input  logic            rst,
  prach_hb4_pair_if.slave bus
);

  localparam int unsigned CHN_W  = 8;
  localparam int unsigned CHN_AW = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1;
  localparam int unsigned DROP_W = 16;
  localparam logic [CHN_W-1:0] CHN_USED = CHN_W'(NUM_CHANNEL_USED);

  // Per-channel state: phase bit plus one held sample
  logic [NUM_CHANNEL-1:0] phase_q;
  logic [NUM_CHANNEL-1:0] phase_d;
  logic [DATA_WIDTH-1:0]  ram_q [NUM_CHANNEL];

  logic                  chn_ok_c;
  logic [CHN_AW-1:0]     addr_c;
  logic                  accept_c;
  logic                  drop_c;
  logic                  phase_rd_c;
  logic                  ram_we_c;
  logic                  pair_c;

  logic                  s1_vld_q;
  logic                  s1_vld_d;
  logic [DATA_WIDTH-1:0] s1_dp1_q;
  logic [DATA_WIDTH-1:0] s1_dp2_q;
  logic [CHN_W-1:0]      s1_chn_q;

  logic [DATA_WIDTH-1:0] dp1_q;
  logic [DATA_WIDTH-1:0] dp2_q;
  logic                  dv_q;
  logic [CHN_W-1:0]      chn_q;
  logic [1:0]            sync_q;
  logic [DROP_W-1:0]     drop_cnt_q;
  logic [DROP_W-1:0]     drop_cnt_d;

  assign chn_ok_c = (bus.din_chn < CHN_USED);
  assign addr_c   = CHN_AW'(bus.din_chn);
  assign accept_c = bus.din_dv && chn_ok_c;
  assign drop_c   = bus.din_dv && !chn_ok_c;

  // Sync wipes held halves before this cycle's sample is classified
  assign phase_rd_c = bus.sync_in ? 1'b0 : phase_q[addr_c];
  assign ram_we_c   = accept_c && !phase_rd_c;
  assign pair_c     = accept_c && phase_rd_c;

  always_comb begin
    phase_d = phase_q;
    if (bus.sync_in) begin
      phase_d = '0;
    end
    if (accept_c) begin
      phase_d[addr_c] = ~phase_rd_c;
    end
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_c && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  assign s1_vld_d = pair_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= '0;
      drop_cnt_q <= '0;
      s1_vld_q   <= 1'b0;
      sync_q     <= '0;
    end else begin
      phase_q    <= phase_d;
      drop_cnt_q <= drop_cnt_d;
      s1_vld_q   <= s1_vld_d;
      sync_q     <= {sync_q[0], bus.sync_in};
    end
  end

  // Distributed RAM: no reset, written only on the first sample of a pair
  always_ff @(posedge clk) begin
    if (ram_we_c) begin
      ram_q[addr_c] <= bus.din_dq;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_dp1_q <= '0;
      s1_dp2_q <= '0;
      s1_chn_q <= '0;
    end else if (pair_c) begin
      s1_dp1_q <= bus.din_dq;
      s1_dp2_q <= ram_q[addr_c];
      s1_chn_q <= bus.din_chn;
    end
  end

  // Output register; data holds between pairs
  always_ff @(posedge clk) begin
    if (rst) begin
      dp1_q <= '0;
      dp2_q <= '0;
      chn_q <= '0;
      dv_q  <= 1'b0;
    end else begin
      dv_q <= s1_vld_q;
      if (s1_vld_q) begin
        dp1_q <= s1_dp1_q;
        dp2_q <= s1_dp2_q;
        chn_q <= s1_chn_q;
      end
    end
  end

  assign bus.dout_dp1 = dp1_q;
  assign bus.dout_dp2 = dp2_q;
  assign bus.dout_dv  = dv_q;
  assign bus.dout_chn = chn_q;
  assign bus.sync_out = sync_q[1];
  assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_prach_hb4_pair.sv
// Self-checking bench for prach_hb4_pair: vector table plus scoreboarded multi-cycle sequences.
module tb_prach_hb4_pair;

  localparam int unsigned DW = 16;

  typedef struct {
    logic [DW-1:0] dp1;
    logic [DW-1:0] dp2;
    logic [7:0]    chn;
    int            cyc;
  } exp_t;

  typedef struct {
    bit            dv;
    bit            sync;
    logic [7:0]    chn;
    logic [DW-1:0] dq;
    bit            ev;
    logic [DW-1:0] edp1;
    logic [DW-1:0] edp2;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prach_hb4_pair_if #(.DATA_WIDTH(DW)) bus();

  prach_hb4_pair #(
    .NUM_CHANNEL(128),
    .NUM_CHANNEL_USED(48),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int exp_sync_cyc = -1;
  exp_t sb[$];
  logic [DW-1:0] last_dp1 = '0;
  logic [DW-1:0] last_dp2 = '0;
  logic [7:0]    last_chn = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: pops the scoreboard on every pair, otherwise checks data hold
  always @(negedge clk) begin
    if (!rst) begin
      chk("sync_out", 64'(bus.sync_out), 64'(cyc == exp_sync_cyc));
      if (bus.dout_dv) begin
        chk("dv_expected", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", 64'(cyc), 64'(e.cyc));
          chk("dp1", 64'(bus.dout_dp1), 64'(e.dp1));
          chk("dp2", 64'(bus.dout_dp2), 64'(e.dp2));
          chk("chn", 64'(bus.dout_chn), 64'(e.chn));
          last_dp1 = e.dp1;
          last_dp2 = e.dp2;
          last_chn = e.chn;
        end
      end else begin
        chk("hold", {24'(0), bus.dout_dp1, bus.dout_dp2, bus.dout_chn},
                    {24'(0), last_dp1, last_dp2, last_chn});
      end
    end
  end

  task automatic step(input bit dv, input bit sync, input logic [7:0] chn, input logic [DW-1:0] dq,
                      input bit ev, input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    exp_t e;
    bus.din_dv  = dv;
    bus.sync_in = sync;
    bus.din_chn = chn;
    bus.din_dq  = dq;
    if (ev) begin
      e.dp1 = e1;
      e.dp2 = e2;
      e.chn = chn;
      e.cyc = cyc + 2;
      sb.push_back(e);
    end
    if (sync) exp_sync_cyc = cyc + 2;
    @(posedge clk);
    #1;
    bus.din_dv  = 1'b0;
    bus.sync_in = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.din_dv  = 1'b0;
    bus.sync_in = 1'b0;
    bus.din_chn = '0;
    bus.din_dq  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dp1", 64'(bus.dout_dp1), 64'(0));
    chk("rst_dp2", 64'(bus.dout_dp2), 64'(0));
    chk("rst_dv", 64'(bus.dout_dv), 64'(0));
    chk("rst_chn", 64'(bus.dout_chn), 64'(0));
    chk("rst_sync_out", 64'(bus.sync_out), 64'(0));
    chk("rst_drop_cnt", 64'(bus.drop_cnt), 64'(0));
    sb.delete();
    last_dp1 = '0;
    last_dp2 = '0;
    last_chn = '0;
    exp_sync_cyc = -1;
    rst = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vec[11];
    vec[0]  = '{1'b1, 1'b0, 8'd0,  16'd100, 1'b0, 16'd0,   16'd0};
    vec[1]  = '{1'b1, 1'b0, 8'd0,  16'd200, 1'b1, 16'd200, 16'd100};
    vec[2]  = '{1'b0, 1'b0, 8'd0,  16'd999, 1'b0, 16'd0,   16'd0};
    vec[3]  = '{1'b0, 1'b0, 8'd0,  16'd0,   1'b0, 16'd0,   16'd0};
    vec[4]  = '{1'b1, 1'b0, 8'd5,  16'd7,   1'b0, 16'd0,   16'd0};
    vec[5]  = '{1'b1, 1'b1, 8'd5,  16'd9,   1'b0, 16'd0,   16'd0};
    vec[6]  = '{1'b1, 1'b0, 8'd5,  16'd11,  1'b1, 16'd11,  16'd9};
    vec[7]  = '{1'b0, 1'b0, 8'd0,  16'd0,   1'b0, 16'd0,   16'd0};
    vec[8]  = '{1'b1, 1'b0, 8'd60, 16'd1,   1'b0, 16'd0,   16'd0};
    vec[9]  = '{1'b1, 1'b0, 8'd60, 16'd2,   1'b0, 16'd0,   16'd0};
    vec[10] = '{1'b1, 1'b0, 8'd60, 16'd3,   1'b0, 16'd0,   16'd0};

    do_reset();
    for (int i = 0; i < 11; i++)
      step(vec[i].dv, vec[i].sync, vec[i].chn, vec[i].dq, vec[i].ev, vec[i].edp1, vec[i].edp2);
    idle(3);
    chk("drop_cnt_3", 64'(bus.drop_cnt), 64'(3));

    // Round-robin over all used channels, two rounds
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 48; c++)
        step(1'b1, 1'b0, 8'(c), 16'(2 * c + r), r == 1, 16'(2 * c + 1), 16'(2 * c));
    idle(3);

    // Same channel with random idle gaps
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 1'b0, 8'd3, 16'(k), (k % 2) == 0, 16'(k), 16'(k - 1));
      idle(int'($urandom_range(0, 5)));
    end
    idle(3);

    // Back-to-back pairs on one channel
    step(1'b1, 1'b0, 8'd47, 16'd500, 1'b0, '0, '0);
    step(1'b1, 1'b0, 8'd47, 16'd501, 1'b1, 16'd501, 16'd500);
    step(1'b1, 1'b0, 8'd47, 16'd502, 1'b0, '0, '0);
    step(1'b1, 1'b0, 8'd47, 16'd503, 1'b1, 16'd503, 16'd502);
    idle(3);

    // Reset discards a held half-pair
    step(1'b1, 1'b0, 8'd9, 16'd50, 1'b0, '0, '0);
    do_reset();
    idle(2);
    step(1'b1, 1'b0, 8'd9, 16'd60, 1'b0, '0, '0);
    step(1'b1, 1'b0, 8'd9, 16'd61, 1'b1, 16'd61, 16'd60);
    idle(3);

    // Drop counter saturation
    for (int i = 0; i < 70000; i++)
      step(1'b1, 1'b0, 8'(48 + (i % 208)), 16'(i), 1'b0, '0, '0);
    idle(2);
    chk("drop_cnt_sat", 64'(bus.drop_cnt), 64'(16'hFFFF));
    step(1'b1, 1'b0, 8'd100, 16'd0, 1'b0, '0, '0);
    idle(1);
    chk("drop_cnt_hold", 64'(bus.drop_cnt), 64'(16'hFFFF));

    idle(4);
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
